// File: rtl/cmp_sorter.sv
// cmp_sorter: frame sorter built on one shared unsigned comparator.
// Loads DEPTH words, bubble-sorts them in place, then streams them out.

module comparator #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

module cmp_sorter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] PEN  = IW'(DEPTH - 2);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    pass;
  logic             swapped;
  logic             done_q;

  logic [IW-1:0]    idx_nx;
  logic             c_eq;
  logic             c_lt;
  logic             c_gt;
  logic             in_fire;
  logic             out_fire;
  logic             do_swap;

  assign idx_nx = idx + ONE;

  comparator #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a (mem[idx]),
    .b (mem[idx_nx]),
    .eq(c_eq),
    .lt(c_lt),
    .gt(c_gt)
  );

  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = (state == DRAIN) && !rst;
  assign busy      = (state == SORT) && !rst;
  assign done      = done_q && !rst;
  assign out_data  = mem[rd_idx];

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // eq/lt leave the pair alone, which keeps equal words in order
  assign do_swap  = busy && c_gt && !(c_eq || c_lt);

  // Control FSM: counters, pass bookkeeping and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      wr_idx  <= '0;
      idx     <= '0;
      rd_idx  <= '0;
      pass    <= '0;
      swapped <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_fire) begin
            wr_idx <= wr_idx + ONE;
            if (wr_idx == LAST) begin
              state   <= SORT;
              wr_idx  <= '0;
              idx     <= '0;
              pass    <= '0;
              swapped <= 1'b0;
            end
          end
        end
        SORT: begin
          if (idx == PEN) begin
            if (!(swapped || c_gt) || (pass == PEN)) begin
              state  <= DRAIN;
              rd_idx <= '0;
            end else begin
              idx     <= '0;
              pass    <= pass + ONE;
              swapped <= 1'b0;
            end
          end else begin
            idx     <= idx_nx;
            swapped <= swapped || c_gt;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            rd_idx <= rd_idx + ONE;
            if (rd_idx == LAST) begin
              state  <= LOAD;
              wr_idx <= '0;
              rd_idx <= '0;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Word storage: load writes and in-place swaps; never reset
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_idx] <= in_data;
    end else if (do_swap) begin
      mem[idx]    <= mem[idx_nx];
      mem[idx_nx] <= mem[idx];
    end
  end

endmodule

// File: tb/tb_cmp_sorter.sv
// tb_cmp_sorter: random and directed frames against a scoreboard.
// Monitor pops expected words whenever the DUT hands one out.

module tb_cmp_sorter;

  localparam int W = 16;
  localparam int D = 8;

  typedef logic [W-1:0] frame_t [D];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q [$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_data  = '0;

  cmp_sorter #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Ascending order by repeated minimum extraction
  function automatic frame_t ref_sort(input frame_t w);
    frame_t       s;
    logic [W-1:0] q [$];
    int           m;
    foreach (w[i]) q.push_back(w[i]);
    for (int k = 0; k < D; k++) begin
      m = 0;
      for (int j = 1; j < q.size(); j++)
        if (q[j] < q[m]) m = j;
      s[k] = q[m];
      q.delete(m);
    end
    return s;
  endfunction

  // Passes = largest left-shift any word needs, plus one clean pass
  function automatic int ref_passes(input frame_t w);
    int mx = 0;
    int c;
    for (int j = 0; j < D; j++) begin
      c = 0;
      for (int i = 0; i < j; i++)
        if (w[i] > w[j]) c++;
      if (c > mx) mx = c;
    end
    return (mx + 1 > D - 1) ? D - 1 : mx + 1;
  endfunction

  // Monitor: scoreboard pops, stall stability, state exclusivity
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        chk("excl", 32'((in_ready && (busy || out_valid)) ||
                        (busy && out_valid)), 0);
        if (stall_prev && out_valid)
          chk("stable", 32'(out_data), 32'(prev_data));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0h required=none",
                     out_data);
          end else begin
            chk("data", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic send_frame(input frame_t w, input bit gaps,
                            input bit push);
    frame_t s;
    int     t;
    if (push) begin
      s = ref_sort(w);
      foreach (s[i]) exp_q.push_back(s[i]);
    end
    busy_cnt = 0;
    for (int i = 0; i < D; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = w[i];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) fail_now("load_timeout");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic recv_frame(input int mode, input int exp_busy);
    int got = 0;
    int t   = 0;
    int cyc = 0;
    int d0  = done_cnt;
    if (mode == 2) begin
      out_ready = 1'b0;
      @(negedge clk);
      while (!out_valid && t < 500) begin
        t++;
        @(negedge clk);
      end
      if (!out_valid) fail_now("drain_timeout");
      for (int k = 0; k < 20; k++) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_min", 32'(out_data), 32'(exp_q[0]));
        if (k < 19) @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    t = 0;
    while (got < D && t < 3000) begin
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 16'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) got++;
      t++;
      cyc++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (got < D) fail_now("recv_timeout");
    if (mode == 2) chk("drain_cycles", 32'(cyc), 8);
    chk("done_now", 32'(done), 1);
    chk("in_ready_after", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 1);
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    frame_t f;
    int     b;
    int     t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    f = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    send_frame(f, 1'b0, 1'b1);
    recv_frame(0, 7);

    f = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    send_frame(f, 1'b0, 1'b1);
    recv_frame(0, 49);

    f = '{16'd5, 16'd6, 16'd6, 16'd5, 16'hFFFF, 16'd0, 16'd5, 16'd6};
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd5);
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd6);
    exp_q.push_back(16'hFFFF);
    send_frame(f, 1'b0, 1'b0);
    recv_frame(0, ref_passes(f) * (D - 1));

    for (int n = 0; n < 10; n++) begin
      foreach (f[i])
        f[i] = ($urandom_range(0, 1) != 0) ? 16'($urandom)
                                          : 16'($urandom_range(0, 3));
      send_frame(f, 1'b1, 1'b1);
      recv_frame(1, ref_passes(f) * (D - 1));
    end

    foreach (f[i]) f[i] = 16'($urandom);
    send_frame(f, 1'b0, 1'b0);
    b = 0;
    t = 0;
    while (b < 3 && t < 200) begin
      @(negedge clk);
      if (busy) b++;
      t++;
    end
    if (b < 3) fail_now("abort_busy");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    f = '{16'd9, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    send_frame(f, 1'b0, 1'b1);
    recv_frame(0, ref_passes(f) * (D - 1));

    foreach (f[i]) f[i] = 16'($urandom);
    send_frame(f, 1'b0, 1'b1);
    recv_frame(2, ref_passes(f) * (D - 1));

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
